// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day keeper.
//   mode_t      : set-mode state encoding, also driven out on the mode port
//   SEC_MAX     : seconds modulus
//   MIN_MAX     : minutes modulus
//   *_W         : field widths for hours / minutes / seconds
package clock_pkg;

    localparam int SEC_MAX = 60;
    localparam int MIN_MAX = 60;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } mode_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up-counter used for each time field.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-low reset, clears value
//   inc   : advance by one, wrapping MAX-1 -> 0
//   clr   : synchronous clear, has priority over inc
//   value : registered count, 0..MAX-1
//   carry : combinational, high when inc would wrap the counter
module wrap_counter #(
    parameter int MAX = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q == LAST) ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == LAST);

endmodule

// File: rtl/clock_time_keeper.sv
// Hours/minutes/seconds time keeper with a three-state set mode.
// Build option: define CLOCK_ALARM_EN to add the alarm compare and its ports.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   tick      : 1 Hz one-cycle pulse, advances the time in RUN
//   mode_btn  : one-cycle pulse, RUN -> SET_H -> SET_M -> RUN
//   inc_btn   : one-cycle pulse, increments the field being set
//   hours     : 0..HOURS_MAX-1
//   minutes   : 0..59
//   seconds   : 0..59
//   mode      : current mode_t encoding
//   alarm_h   : alarm hour   (CLOCK_ALARM_EN only)
//   alarm_m   : alarm minute (CLOCK_ALARM_EN only)
//   alarm_hit : one-cycle pulse alongside the tick update that reaches hh:mm:00
//               (CLOCK_ALARM_EN only)
//
// state | meaning
// RUN   | time advances on tick, inc_btn ignored
// SET_H | time frozen, inc_btn steps hours
// SET_M | time frozen, inc_btn steps minutes; leaving clears seconds
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int HOURS_MAX = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              mode_btn,
    input  logic              inc_btn,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [1:0]        mode
`ifdef CLOCK_ALARM_EN
    ,
    input  logic [HOUR_W-1:0] alarm_h,
    input  logic [MIN_W-1:0]  alarm_m,
    output logic              alarm_hit
`endif
);

    mode_t state_q;
    mode_t state_d;

    logic running;
    logic sec_inc;
    logic sec_clr;
    logic sec_carry;
    logic min_inc;
    logic min_carry;
    logic hr_inc;

    always_comb begin
        state_d = state_q;
        if (mode_btn) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign mode = state_q;

    // Counter controls use the current state, so a tick arriving with the
    // RUN->SET_H mode_btn is still applied. In the set states mode_btn
    // suppresses inc_btn, and minute edits never ripple into hours because
    // hr_inc only follows min_carry while running.
    always_comb begin
        running = (state_q == RUN);
        sec_inc = running && tick;
        sec_clr = (state_q == SET_M) && mode_btn;
        min_inc = running ? sec_carry
                          : ((state_q == SET_M) && inc_btn && !mode_btn);
        hr_inc  = running ? min_carry
                          : ((state_q == SET_H) && inc_btn && !mode_btn);
    end

    wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (seconds),
        .carry (sec_carry)
    );

    wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (minutes),
        .carry (min_carry)
    );

`ifdef CLOCK_ALARM_EN
    logic              hr_carry;
    logic              alarm_hit_q;
    logic              alarm_hit_d;
    logic [HOUR_W-1:0] hr_next;
    logic [MIN_W-1:0]  min_next;

    wrap_counter #(.MAX(HOURS_MAX), .W(HOUR_W)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hr_inc),
        .clr   (1'b0),
        .value (hours),
        .carry (hr_carry)
    );

    // Compare against the values the counters are about to load so the
    // registered pulse lines up with the hh:mm:00 output. sec_carry already
    // implies RUN with a tick, and a seconds wrap means the new seconds is 0.
    always_comb begin
        min_next    = min_carry ? '0 : minutes + MIN_W'(1);
        hr_next     = hr_carry  ? '0 : (min_carry ? hours + HOUR_W'(1) : hours);
        alarm_hit_d = sec_carry && (hr_next == alarm_h) && (min_next == alarm_m);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    wrap_counter #(.MAX(HOURS_MAX), .W(HOUR_W)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hr_inc),
        .clr   (1'b0),
        .value (hours),
        .carry ()
    );
`endif

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper: a 24-hour and a 12-hour
// instance, each followed by a reference time model whose expected outputs
// are queued as stimulus is driven and popped one cycle later.
module tb_clock_time_keeper;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
    } snap_t;

    localparam bit [2:0] T = 3'b100;
    localparam bit [2:0] M = 3'b010;
    localparam bit [2:0] I = 3'b001;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic       tick, mode_btn, inc_btn;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [1:0] mode;

    logic       tick12, mode_btn12, inc_btn12;
    logic [4:0] hours12;
    logic [5:0] minutes12, seconds12;
    logic [1:0] mode12;

    int al_h = 0;
    int al_m = 2;

`ifdef CLOCK_ALARM_EN
    logic [4:0] alarm_h, alarm_h12;
    logic [5:0] alarm_m, alarm_m12;
    logic       alarm_hit, alarm_hit12;
`endif

    clock_time_keeper #(.HOURS_MAX(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .mode      (mode)
`ifdef CLOCK_ALARM_EN
        ,
        .alarm_h   (alarm_h),
        .alarm_m   (alarm_m),
        .alarm_hit (alarm_hit)
`endif
    );

    clock_time_keeper #(.HOURS_MAX(12)) dut12 (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick12),
        .mode_btn  (mode_btn12),
        .inc_btn   (inc_btn12),
        .hours     (hours12),
        .minutes   (minutes12),
        .seconds   (seconds12),
        .mode      (mode12)
`ifdef CLOCK_ALARM_EN
        ,
        .alarm_h   (alarm_h12),
        .alarm_m   (alarm_m12),
        .alarm_hit (alarm_hit12)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    snap_t    sb_q[$];
    snap_t    sb12_q[$];
    bit       hit_q[$];
    bit [2:0] cmds[$];

    int mh, mm, ms, mmd;
    int h12, m12, s12, md12;

    function automatic snap_t mk(input int h, input int m, input int s, input int md);
        snap_t r;
        r.h  = 5'(h);
        r.m  = 6'(m);
        r.s  = 6'(s);
        r.md = 2'(md);
        return r;
    endfunction

    // Reference model: time kept as seconds-since-midnight in RUN.
    task automatic model_step(input int hm, input bit t, input bit mb, input bit ib,
                              inout int h, inout int m, inout int s, inout int md,
                              output bit hit);
        int tot;
        hit = 1'b0;
        case (md)
            0: begin
                if (t) begin
                    tot = (h * 3600 + m * 60 + s + 1) % (hm * 3600);
                    h = tot / 3600;
                    m = (tot / 60) % 60;
                    s = tot % 60;
                    hit = (s == 0) && (h == al_h) && (m == al_m);
                end
                if (mb) md = 1;
            end
            1: begin
                if (mb) md = 2;
                else if (ib) h = (h + 1) % hm;
            end
            default: begin
                if (mb) begin
                    md = 0;
                    s = 0;
                end else if (ib) begin
                    m = (m + 1) % 60;
                end
            end
        endcase
    endtask

    task automatic drive(input bit [2:0] c);
        bit hit;
        tick = c[2];
        mode_btn = c[1];
        inc_btn = c[0];
        model_step(24, c[2], c[1], c[0], mh, mm, ms, mmd, hit);
        sb_q.push_back(mk(mh, mm, ms, mmd));
        hit_q.push_back(hit);
        @(posedge clk);
        #1;
        tick = 1'b0;
        mode_btn = 1'b0;
        inc_btn = 1'b0;
    endtask

    task automatic drive12(input bit [2:0] c);
        bit hit;
        tick12 = c[2];
        mode_btn12 = c[1];
        inc_btn12 = c[0];
        model_step(12, c[2], c[1], c[0], h12, m12, s12, md12, hit);
        sb12_q.push_back(mk(h12, m12, s12, md12));
        @(posedge clk);
        #1;
        tick12 = 1'b0;
        mode_btn12 = 1'b0;
        inc_btn12 = 1'b0;
    endtask

    task automatic add(input bit [2:0] c, input int n);
        for (int k = 0; k < n; k++) cmds.push_back(c);
    endtask

    task automatic reset_models();
        mh = 0; mm = 0; ms = 0; mmd = 0;
        h12 = 0; m12 = 0; s12 = 0; md12 = 0;
        sb_q.delete();
        sb12_q.delete();
        hit_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_models();
    endtask

    task automatic test_reset();
        snap_t e;
        reset_models();
        #25;
        sb_q.push_back(mk(mh, mm, ms, mmd));
        e = sb_q.pop_front();
        n_total++;
        if ({hours, minutes, seconds, mode} !== e)
            $display("FAIL reset: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                     hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
        else n_pass++;
`ifdef CLOCK_ALARM_EN
        n_total++;
        if (alarm_hit !== 1'b0) $display("FAIL reset_alarm: got %0b, want 0", alarm_hit);
        else n_pass++;
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_count61();
        snap_t e;
        for (int i = 0; i < 122; i++) begin
            drive((i % 2 == 1) ? T : 3'b000);
            e = sb_q.pop_front();
            n_total++;
            if ({hours, minutes, seconds, mode} !== e)
                $display("FAIL count61 step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(0, 1, 1, 0))
            $display("FAIL count61_end: got %0d:%0d:%0d mode %0d, want 0:1:1 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;
    endtask

    task automatic test_set_mode();
        snap_t e;
        do_reset();
        cmds.delete();
        add(T, 17);
        add(M, 1); add(I, 1); add(T, 1); add(I, 2);
        add(M, 1); add(I, 1); add(T, 1); add(I, 4);
        add(M, 1);
        for (int i = 0; i < cmds.size(); i++) begin
            drive(cmds[i]);
            e = sb_q.pop_front();
            n_total++;
            if ({hours, minutes, seconds, mode} !== e)
                $display("FAIL set_mode step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(3, 5, 0, 0))
            $display("FAIL set_mode_end: got %0d:%0d:%0d mode %0d, want 3:5:0 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;
    endtask

    task automatic test_cascade();
        snap_t e;
        do_reset();
        cmds.delete();
        add(M, 1); add(I, 23); add(M, 1); add(I, 59); add(M, 1); add(T, 59);
        for (int i = 0; i < cmds.size(); i++) begin
            drive(cmds[i]);
            e = sb_q.pop_front();
            n_total++;
            if ({hours, minutes, seconds, mode} !== e)
                $display("FAIL cascade_load step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(23, 59, 59, 0))
            $display("FAIL cascade_pre: got %0d:%0d:%0d mode %0d, want 23:59:59 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;
        drive(T);
        e = sb_q.pop_front();
        n_total++;
        if ({hours, minutes, seconds, mode} !== e)
            $display("FAIL cascade_wrap: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                     hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
        else n_pass++;
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(0, 0, 0, 0))
            $display("FAIL cascade_zero: got %0d:%0d:%0d mode %0d, want 0:0:0 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;

        cmds.delete();
        add(M, 1); add(I, 12); add(M, 1); add(I, 34); add(M, 1); add(T, 56);
        for (int i = 0; i < cmds.size(); i++) begin
            drive(cmds[i]);
            e = sb_q.pop_front();
            n_total++;
            if ({hours, minutes, seconds, mode} !== e)
                $display("FAIL preload step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(12, 34, 56, 0))
            $display("FAIL preload_end: got %0d:%0d:%0d mode %0d, want 12:34:56 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;
    endtask

    task automatic test_collision();
        snap_t e;
        do_reset();
        cmds.delete();
        add(T | M, 1); add(M | I, 1); add(I, 1);
        for (int i = 0; i < cmds.size(); i++) begin
            drive(cmds[i]);
            e = sb_q.pop_front();
            n_total++;
            if ({hours, minutes, seconds, mode} !== e)
                $display("FAIL collision step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(0, 1, 1, 2))
            $display("FAIL collision_end: got %0d:%0d:%0d mode %0d, want 0:1:1 mode 2",
                     hours, minutes, seconds, mode);
        else n_pass++;

        // Reset between clock edges must clear the outputs immediately.
        #5;
        rst = 1'b0;
        #1;
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(0, 0, 0, 0))
            $display("FAIL async_reset: got %0d:%0d:%0d mode %0d, want 0:0:0 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_models();

        cmds.delete();
        add(I, 1); add(T, 1);
        for (int i = 0; i < cmds.size(); i++) begin
            drive(cmds[i]);
            e = sb_q.pop_front();
            n_total++;
            if ({hours, minutes, seconds, mode} !== e)
                $display("FAIL post_reset step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours, minutes, seconds, mode, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours, minutes, seconds, mode} !== mk(0, 0, 1, 0))
            $display("FAIL first_tick: got %0d:%0d:%0d mode %0d, want 0:0:1 mode 0",
                     hours, minutes, seconds, mode);
        else n_pass++;
    endtask

    task automatic test_hours12();
        snap_t e;
        do_reset();
        cmds.delete();
        add(M, 1); add(I, 11); add(M, 1); add(I, 59); add(M, 1); add(T, 59);
        for (int i = 0; i < cmds.size(); i++) begin
            drive12(cmds[i]);
            e = sb12_q.pop_front();
            n_total++;
            if ({hours12, minutes12, seconds12, mode12} !== e)
                $display("FAIL h12_load step %0d: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                         i, hours12, minutes12, seconds12, mode12, e.h, e.m, e.s, e.md);
            else n_pass++;
        end
        n_total++;
        if ({hours12, minutes12, seconds12, mode12} !== mk(11, 59, 59, 0))
            $display("FAIL h12_pre: got %0d:%0d:%0d mode %0d, want 11:59:59 mode 0",
                     hours12, minutes12, seconds12, mode12);
        else n_pass++;
        drive12(T);
        e = sb12_q.pop_front();
        n_total++;
        if ({hours12, minutes12, seconds12, mode12} !== e)
            $display("FAIL h12_wrap: got %0d:%0d:%0d mode %0d, want %0d:%0d:%0d mode %0d",
                     hours12, minutes12, seconds12, mode12, e.h, e.m, e.s, e.md);
        else n_pass++;
        n_total++;
        if ({hours12, minutes12, seconds12, mode12} !== mk(0, 0, 0, 0))
            $display("FAIL h12_zero: got %0d:%0d:%0d mode %0d, want 0:0:0 mode 0",
                     hours12, minutes12, seconds12, mode12);
        else n_pass++;
    endtask

`ifdef CLOCK_ALARM_EN
    task automatic test_alarm();
        snap_t e;
        bit    eh;
        int    hits = 0;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            drive(T);
            e = sb_q.pop_front();
            eh = hit_q.pop_front();
            n_total++;
            if (alarm_hit !== eh)
                $display("FAIL alarm step %0d: got %0b, want %0b", i, alarm_hit, eh);
            else n_pass++;
            if (alarm_hit === 1'b1) begin
                hits++;
                n_total++;
                if ({hours, minutes, seconds, mode} !== mk(0, 2, 0, 0))
                    $display("FAIL alarm_time: got %0d:%0d:%0d mode %0d, want 0:2:0 mode 0",
                             hours, minutes, seconds, mode);
                else n_pass++;
            end
        end
        n_total++;
        if (hits !== 1) $display("FAIL alarm_count: got %0d pulses, want 1", hits);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b0;
        tick = 1'b0;
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        tick12 = 1'b0;
        mode_btn12 = 1'b0;
        inc_btn12 = 1'b0;
`ifdef CLOCK_ALARM_EN
        alarm_h = 5'(al_h);
        alarm_m = 6'(al_m);
        alarm_h12 = 5'd31;
        alarm_m12 = 6'd63;
`endif
        test_reset();
        test_count61();
        test_set_mode();
        test_cascade();
        test_collision();
        test_hours12();
`ifdef CLOCK_ALARM_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
